// File: rtl/shift_result_unrev_stage_if.sv
// Valid/ready stream carrying one shift result plus its left-shift flag.
// Latency: none, this is wiring only.
// Backpressure: ready is driven by the consumer and valid by the producer.
interface shift_result_unrev_stage_if #(
  parameter int N = 8
);
  logic         valid;
  logic         ready;
  logic         left;
  logic [N-1:0] data;

  modport master (output valid, output data, output left, input ready);
  modport slave  (input valid, input data, input left, output ready);
endinterface

// File: rtl/shift_result_unrev_stage.sv
// Un-reverses left-shift results from the right-only shifter core and registers them.
// Latency: 1 cycle from accept to out valid, 1 result/cycle sustained.
// Backpressure: 2-entry skid buffer, in ready depends on the skid flop only.
module shift_result_unrev_stage #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  shift_result_unrev_stage_if.slave   in_if,
  shift_result_unrev_stage_if.master  out_if,
  output logic [CW-1:0]               xfer_count
);

  logic         main_valid;
  logic [N-1:0] main_data;
  logic         main_left;
  logic         skid_valid;
  logic [N-1:0] skid_data;
  logic         skid_left;
  logic [N-1:0] d;
  logic         in_ready;
  logic         accept;
  logic         fire;

  // Bit-reverse the core result when it came from a left shift.
  always_comb begin
    d = in_if.data;
    if (in_if.left) begin
      for (int i = 0; i < N; i++) begin
        d[i] = in_if.data[N-1-i];
      end
    end
  end

  // Ready comes from the skid flop (and reset) only, never from out ready.
  assign in_ready = ~skid_valid & ~rst;
  assign accept   = in_if.valid & in_ready;
  assign fire     = main_valid & out_if.ready;

  assign in_if.ready  = in_ready;
  assign out_if.valid = main_valid;
  assign out_if.data  = main_data;
  assign out_if.left  = main_left;

  // Main/skid register update; the skid entry is always older than any new input.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_left  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_left  <= 1'b0;
    end else if (~main_valid | out_if.ready) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_left  <= skid_left;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= d;
        main_left  <= in_if.left;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= d;
      skid_left  <= in_if.left;
    end
  end

  // Wrapping debug count of delivered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (fire) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_result_unrev_stage.sv
// Bench for shift_result_unrev_stage: queue model plus directed literal checks.
// Latency: model tracks accepted results as an in-order queue of at most two.
// Backpressure: out ready driven directly and randomly in the streaming phase.
module tb_shift_result_unrev_stage;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_result_unrev_stage_if #(.N(N)) in_if ();
  shift_result_unrev_stage_if #(.N(N)) out_if ();
  shift_result_unrev_stage_if #(.N(N)) w_in ();
  shift_result_unrev_stage_if #(.N(N)) w_out ();
  logic [15:0] xfer_count;
  logic [1:0]  xfer_w;

  shift_result_unrev_stage #(.N(N), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_if(in_if.slave), .out_if(out_if.master),
    .xfer_count(xfer_count)
  );

  // Narrow-counter instance fed the same stimulus to exercise the wrap.
  assign w_in.valid   = in_if.valid;
  assign w_in.left    = in_if.left;
  assign w_in.data    = in_if.data;
  assign w_out.ready  = out_if.ready;

  shift_result_unrev_stage #(.N(N), .CW(2)) dut_w (
    .clk(clk), .rst(rst), .in_if(w_in.slave), .out_if(w_out.master),
    .xfer_count(xfer_w)
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rev(input logic [N-1:0] x);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = x[N-1-i];
    return r;
  endfunction

  // Model: in-order queue of {left, data} for results held by the block.
  logic [N:0] q[$];
  int unsigned mcount = 0;

  always @(posedge clk) begin
    bit fire_m, acc_m;
    if (rst) begin
      q.delete();
      mcount = 0;
    end else begin
      fire_m = (q.size() > 0) && out_if.ready;
      acc_m  = in_if.valid && (q.size() < 2);
      if (fire_m) begin
        void'(q.pop_front());
        mcount = mcount + 1;
      end
      if (acc_m) q.push_back({in_if.left, in_if.left ? rev(in_if.data) : in_if.data});
    end
  end

  // Compare every cycle, away from the clock edge.
  always @(negedge clk) begin
    logic [N:0] head;
    logic [31:0] mc;
    if (started) begin
      mc = mcount;
      chk("in_ready", {31'd0, in_if.ready}, {31'd0, (!rst && q.size() < 2)});
      chk("out_valid", {31'd0, out_if.valid}, {31'd0, (q.size() > 0)});
      chk("out_valid_w", {31'd0, w_out.valid}, {31'd0, (q.size() > 0)});
      if (q.size() > 0) begin
        head = q[0];
        chk("out_data", {24'd0, out_if.data}, {24'd0, head[N-1:0]});
        chk("out_left", {31'd0, out_if.left}, {31'd0, head[N]});
      end
      chk("xfer_count", {16'd0, xfer_count}, {16'd0, mc[15:0]});
      chk("xfer_count_w", {30'd0, xfer_w}, {30'd0, mc[1:0]});
    end
  end

  task automatic drive(input logic v, input logic l, input logic [7:0] d, input logic r);
    in_if.valid  = v;
    in_if.left   = l;
    in_if.data   = d;
    out_if.ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] wrap_exp [5];
    bit acc;
    int sent;
    logic [7:0] sd;
    logic sl;
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    drive(0, 0, 8'h00, 0);
    rst = 1'b1;
    tick();
    tick();
    started = 1'b1;
    chk("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_if.ready}, 32'd0);
    chk("rst_xfer", {16'd0, xfer_count}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_if.ready}, 32'd1);

    // Left un-reverse.
    drive(1, 1, 8'b0110_1000, 1);
    tick();
    chk("t1_valid", {31'd0, out_if.valid}, 32'd1);
    chk("t1_data", {24'd0, out_if.data}, 32'h16);
    chk("t1_left", {31'd0, out_if.left}, 32'd1);
    drive(0, 0, 8'h00, 1);
    tick();
    chk("t1_xfer", {16'd0, xfer_count}, 32'd1);
    chk("t1_idle", {31'd0, out_if.valid}, 32'd0);

    // Right passthrough then left, back to back.
    drive(1, 0, 8'b0010_1101, 1);
    tick();
    chk("t2_right", {24'd0, out_if.data}, 32'h2d);
    chk("t2_right_left", {31'd0, out_if.left}, 32'd0);
    drive(1, 1, 8'b0010_1101, 1);
    tick();
    chk("t2_nobubble", {31'd0, out_if.valid}, 32'd1);
    chk("t2_left", {24'd0, out_if.data}, 32'hb4);
    drive(0, 0, 8'h00, 1);
    tick();
    chk("t2_xfer", {16'd0, xfer_count}, 32'd3);

    // Backpressure into the skid.
    drive(1, 0, 8'h01, 0);
    tick();
    chk("t3_a_data", {24'd0, out_if.data}, 32'h01);
    chk("t3_a_ready", {31'd0, in_if.ready}, 32'd1);
    drive(1, 1, 8'h80, 0);
    tick();
    chk("t3_full_ready", {31'd0, in_if.ready}, 32'd0);
    chk("t3_hold_data", {24'd0, out_if.data}, 32'h01);
    drive(0, 0, 8'h00, 0);
    tick();
    chk("t3_stall_data", {24'd0, out_if.data}, 32'h01);
    chk("t3_stall_left", {31'd0, out_if.left}, 32'd0);
    drive(0, 0, 8'h00, 1);
    tick();
    chk("t3_b_data", {24'd0, out_if.data}, 32'h01);
    chk("t3_b_left", {31'd0, out_if.left}, 32'd1);
    chk("t3_reopen", {31'd0, in_if.ready}, 32'd1);
    tick();
    chk("t3_xfer", {16'd0, xfer_count}, 32'd5);
    chk("t3_empty", {31'd0, out_if.valid}, 32'd0);

    // Streaming with random backpressure.
    sent = 0;
    sd = 8'($urandom);
    sl = 1'($urandom);
    for (int c = 0; c < 400 && sent < 16; c++) begin
      drive(1, sl, sd, 1'($urandom_range(0, 1)));
      acc = in_if.ready;
      tick();
      if (acc) begin
        sent++;
        sd = 8'($urandom);
        sl = 1'($urandom);
      end
    end
    chk("t4_sent", sent, 32'd16);
    drive(0, 0, 8'h00, 1);
    for (int c = 0; c < 10 && out_if.valid; c++) tick();
    chk("t4_drained", {31'd0, out_if.valid}, 32'd0);
    chk("t4_xfer", {16'd0, xfer_count}, 32'd21);

    // Reset mid-stall.
    drive(1, 0, 8'h11, 0);
    tick();
    drive(1, 0, 8'h22, 0);
    tick();
    chk("t5_full", {31'd0, in_if.ready}, 32'd0);
    drive(0, 0, 8'h00, 0);
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", {31'd0, in_if.ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_valid", {31'd0, out_if.valid}, 32'd0);
    chk("t5_xfer", {16'd0, xfer_count}, 32'd0);
    chk("t5_ready", {31'd0, in_if.ready}, 32'd1);
    drive(1, 1, 8'hc0, 1);
    tick();
    chk("t5_new_data", {24'd0, out_if.data}, 32'h03);
    drive(0, 0, 8'h00, 1);
    tick();
    chk("t5_alone", {31'd0, out_if.valid}, 32'd0);
    chk("t5_xfer1", {16'd0, xfer_count}, 32'd1);

    // Counter wrap on the 2-bit instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(i < 5, 0, 8'(i), 1);
      tick();
      if (i >= 1) chk("t6_wrap", {30'd0, xfer_w}, {30'd0, wrap_exp[i-1]});
    end
    drive(0, 0, 8'h00, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_result_unrev_stage.md
Name: shift_result_unrev_stage

Overview:
- Output end of the barrel shifter datapath. The core shifts right only; left shifts are done by reversing the operand on entry.
- This block takes the core's right-shifted result plus the left flag. It reverses the result back when left=1.
- It registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the shifter can be backpressured without a combinational ready path.
- It also keeps a wrapping count of delivered results for debug.

Parameters:
- N, 8, data width in bits (N >= 2).
- CW, 16, width of the delivered-result counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  block can accept a result this cycle.
- in_left  input  1  1 = result belongs to a left shift and must be un-reversed.
- in_data  input  N  right-shifted result from the shifter core.
- out_valid  output  1  out_data/out_left hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_data  output  N  final shift result.
- out_left  output  1  in_left of the delivered result, passed through.
- xfer_count  output  CW  number of completed output transfers, modulo 2^CW.

Behaviour:
- Transform applied on accept:
  - d = in_left ? bit-reverse(in_data) : in_data, where d[i] = in_data[N-1-i].
  - Pure bit permutation: no fill, sign or width change.
- State:
  - Main register {out_valid, out_data, out_left}.
  - Skid register {skid_valid, skid_data, skid_left}.
  - Counter xfer_count.
- Handshake signals:
  - in_ready = ~skid_valid & ~rst. It depends on flops only, with no combinational path from out_ready.
  - accept = in_valid & in_ready.
  - fire = out_valid & out_ready.
- Per-cycle update, in priority order:
  - If ~out_valid | out_ready (main free or draining):
    - if skid_valid: main <= skid; skid_valid <= 0 (no accept can occur, since in_ready=0);
    - else if accept: main <= {1, d, in_left};
    - else out_valid <= 0.
  - Else (main stalled): if accept, skid <= {1, d, in_left}.
  - Fire and accept in the same cycle with the skid empty: main loads the new result. No bubble, full throughput.
- Latency: 1 cycle from accept to out_valid with no backpressure. Sustains 1 result/cycle.
- Stability: while out_valid & ~out_ready, out_data and out_left must not change.
- Order: results leave in acceptance order. The skid entry is always older than any later input.
- Full condition: skid_valid=1 forces in_ready=0. in_ready reasserts the cycle after the skid drains into main.
- Counter: xfer_count increments by 1 on each fire and wraps from 2^CW-1 to 0. It is unaffected by accept.
- Reset (synchronous, any cycle, including mid-stall):
  - out_valid=0, out_data=0, out_left=0, skid_valid=0, skid_data=0, skid_left=0, xfer_count=0, in_ready=0.
  - Any held results are discarded.
  - in_ready=1 in the first cycle after rst deasserts.
- No X propagation: the data registers load only on the update conditions above.

Test Plan (N=8):
- Left un-reverse: in_data=0110_1000, in_left=1, out_ready=1 -> next cycle out_valid=1, out_data=0001_0110, out_left=1, then xfer_count=1.
- Right passthrough then left: in_data=0010_1101 with left=0 -> out 0010_1101; same data with left=1 -> out 1011_0100; back-to-back, no bubble.
- Backpressure/skid: hold out_ready=0 and send A=0x01 (left=0) then B=0x80 (left=1) -> in_ready drops after B is accepted; out_data stays 0x01. Raise out_ready -> outputs 0x01, then 0x01 (B reversed); in_ready=1 again after the skid drains; xfer_count=2.
- Streaming: 16 consecutive results with random out_ready -> scoreboard matches the reversal model in order, no drops or duplicates, and out_data stays stable while stalled.
- Reset mid-stall: fill main and skid, assert rst for 1 cycle -> out_valid=0, in_ready=0 during rst, xfer_count=0; the next result after reset appears alone.
- Counter wrap (CW=2): 5 transfers -> xfer_count sequence 1,2,3,0,1.
